// File: rtl/conv_transposed_3d_sched.sv
// Command scheduler for a 3-D transposed convolution: clears every output voxel,
// then streams one MAC command per (input voxel, channel pair, kernel tap).
module conv_transposed_3d_sched #(
  parameter int N  = 4,
  parameter int K  = 3,
  parameter int S  = 2,
  parameter int CI = 2,
  parameter int CO = 2,
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          dp_idle,
  output logic          busy,
  output logic          done,
  output logic          cmd_valid,
  input  logic          cmd_ready,
  output logic [1:0]    cmd_op,
  output logic [AW-1:0] cmd_in_addr,
  output logic [AW-1:0] cmd_w_addr,
  output logic [AW-1:0] cmd_out_addr,
  output logic          cmd_last
);

  localparam int O    = (N - 1) * S + K;
  localparam int MAXB = (O > CI) ? ((O > CO) ? O : CO) : ((CI > CO) ? CI : CO);
  localparam int CW   = $clog2(MAXB + 1);
  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_MAC   = 2'b01;

  localparam longint OUT_SPAN = longint'(CO) * O * O * O;
  localparam longint IN_SPAN  = longint'(CI) * N * N * N;
  localparam longint W_SPAN   = longint'(CI) * CO * K * K * K;
  localparam longint AW_SPAN  = longint'(1) << AW;

  if ((OUT_SPAN > AW_SPAN) || (IN_SPAN > AW_SPAN) || (W_SPAN > AW_SPAN)) begin : g_addr_overflow
    $error("conv_transposed_3d_sched: address space exceeds AW bits");
  end

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e        state_q, state_d;
  // clr: co, od, oh, ow; run: id, ih, iw, ci, co, kd, kh, kw (last index innermost)
  logic [CW-1:0] clr_q [4];
  logic [CW-1:0] clr_d [4];
  logic [CW-1:0] clr_inc [4];
  logic [CW-1:0] run_q [8];
  logic [CW-1:0] run_d [8];
  logic [CW-1:0] run_inc [8];
  logic          xfer;
  logic          clr_last, run_last;
  logic [1:0]    op_d;
  logic [AW-1:0] in_d, w_d, out_d;
  logic          last_d;
  logic          valid_q, busy_q, done_q, last_q;
  logic [1:0]    op_q;
  logic [AW-1:0] in_q, w_q, out_q;

  function automatic int clr_bound(input int i);
    return (i == 0) ? CO : O;
  endfunction

  function automatic int run_bound(input int i);
    case (i)
      0, 1, 2: return N;
      3:       return CI;
      4:       return CO;
      default: return K;
    endcase
  endfunction

  assign xfer = valid_q & cmd_ready;

  always_comb begin
    logic carry;
    carry = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      if (carry && (int'(clr_q[i]) == clr_bound(i) - 1)) begin
        clr_inc[i] = '0;
      end else if (carry) begin
        clr_inc[i] = clr_q[i] + CW'(1);
        carry      = 1'b0;
      end else begin
        clr_inc[i] = clr_q[i];
      end
    end
    carry = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      if (carry && (int'(run_q[i]) == run_bound(i) - 1)) begin
        run_inc[i] = '0;
      end else if (carry) begin
        run_inc[i] = run_q[i] + CW'(1);
        carry      = 1'b0;
      end else begin
        run_inc[i] = run_q[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    run_d   = run_q;
    case (state_q)
      S_IDLE:  state_d = start ? S_CLEAR : S_IDLE;
      S_CLEAR: begin
        if (xfer) begin
          clr_d   = clr_inc;
          state_d = last_q ? S_RUN : S_CLEAR;
        end else begin
          state_d = S_CLEAR;
        end
      end
      S_RUN: begin
        if (xfer) begin
          run_d   = run_inc;
          state_d = last_q ? S_DRAIN : S_RUN;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: state_d = dp_idle ? S_DONE : S_DRAIN;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Fields of the command that will be presented next cycle, derived from next-state counters
  always_comb begin
    clr_last = 1'b1;
    run_last = 1'b1;
    for (int i = 0; i < 4; i++) clr_last = clr_last & (int'(clr_d[i]) == clr_bound(i) - 1);
    for (int i = 0; i < 8; i++) run_last = run_last & (int'(run_d[i]) == run_bound(i) - 1);
    op_d   = OP_CLEAR;
    in_d   = '0;
    w_d    = '0;
    out_d  = '0;
    last_d = 1'b0;
    case (state_d)
      S_CLEAR: begin
        out_d  = AW'(((int'(clr_d[0]) * O + int'(clr_d[1])) * O + int'(clr_d[2])) * O
                     + int'(clr_d[3]));
        last_d = clr_last;
      end
      S_RUN: begin
        op_d   = OP_MAC;
        in_d   = AW'(((int'(run_d[3]) * N + int'(run_d[0])) * N + int'(run_d[1])) * N
                     + int'(run_d[2]));
        w_d    = AW'((((int'(run_d[3]) * CO + int'(run_d[4])) * K + int'(run_d[5])) * K
                      + int'(run_d[6])) * K + int'(run_d[7]));
        out_d  = AW'(((int'(run_d[4]) * O + (int'(run_d[0]) * S + int'(run_d[5]))) * O
                      + (int'(run_d[1]) * S + int'(run_d[6]))) * O
                     + (int'(run_d[2]) * S + int'(run_d[7])));
        last_d = run_last;
      end
      default: begin
        op_d   = OP_CLEAR;
        last_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      for (int i = 0; i < 4; i++) clr_q[i] <= '0;
      for (int i = 0; i < 8; i++) run_q[i] <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      last_q  <= 1'b0;
      op_q    <= OP_CLEAR;
      in_q    <= '0;
      w_q     <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      run_q   <= run_d;
      valid_q <= (state_d == S_CLEAR) || (state_d == S_RUN);
      busy_q  <= (state_d == S_CLEAR) || (state_d == S_RUN) || (state_d == S_DRAIN);
      done_q  <= (state_d == S_DONE);
      last_q  <= last_d;
      op_q    <= op_d;
      in_q    <= in_d;
      w_q     <= w_d;
      out_q   <= out_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign cmd_valid    = valid_q;
  assign cmd_op       = op_q;
  assign cmd_in_addr  = in_q;
  assign cmd_w_addr   = w_q;
  assign cmd_out_addr = out_q;
  assign cmd_last     = last_q;

endmodule

// File: tb/tb_conv_transposed_3d_sched.sv
// Directed bench for conv_transposed_3d_sched with N=2, K=2, S=2, CI=1, CO=1 (O=4).
module tb_conv_transposed_3d_sched;

  localparam int AW   = 16;
  localparam int NTOT = 128;

  logic          clk = 1'b0;
  logic          rst, start, dp_idle, cmd_ready;
  logic          busy, done, cmd_valid, cmd_last;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_in_addr, cmd_w_addr, cmd_out_addr;

  int total = 0;
  int bad   = 0;

  logic [1:0]    m_op [NTOT];
  logic [AW-1:0] m_in [NTOT];
  logic [AW-1:0] m_w  [NTOT];
  logic [AW-1:0] m_out[NTOT];
  logic          m_last[NTOT];
  logic [1:0]    l_op [NTOT];
  logic [AW-1:0] l_in [NTOT];
  logic [AW-1:0] l_w  [NTOT];
  logic [AW-1:0] l_out[NTOT];
  logic          l_last[NTOT];

  int            xcnt = 0;
  logic          stall_q = 1'b0;
  logic [1:0]    h_op;
  logic [AW-1:0] h_in, h_w, h_out;
  logic          h_last;

  typedef struct {
    int            idx;
    logic [1:0]    op;
    logic [AW-1:0] in_a;
    logic [AW-1:0] w_a;
    logic [AW-1:0] out_a;
    logic          last;
  } vec_t;
  vec_t tbl[9];

  always #5 clk = ~clk;

  conv_transposed_3d_sched #(.N(2), .K(2), .S(2), .CI(1), .CO(1), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .dp_idle(dp_idle), .busy(busy), .done(done),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_in_addr(cmd_in_addr), .cmd_w_addr(cmd_w_addr), .cmd_out_addr(cmd_out_addr),
    .cmd_last(cmd_last)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transfer monitor: checks each handshake against the model and that stalled fields hold
  always @(negedge clk) begin
    if (!rst) begin
      if (stall_q) begin
        chk("stall_valid", 64'(cmd_valid), 64'd1);
        chk("stall_op", 64'(cmd_op), 64'(h_op));
        chk("stall_in", 64'(cmd_in_addr), 64'(h_in));
        chk("stall_w", 64'(cmd_w_addr), 64'(h_w));
        chk("stall_out", 64'(cmd_out_addr), 64'(h_out));
        chk("stall_last", 64'(cmd_last), 64'(h_last));
      end
      if (cmd_valid && cmd_ready) begin
        if (xcnt < NTOT) begin
          chk("seq_op", 64'(cmd_op), 64'(m_op[xcnt]));
          chk("seq_in", 64'(cmd_in_addr), 64'(m_in[xcnt]));
          chk("seq_w", 64'(cmd_w_addr), 64'(m_w[xcnt]));
          chk("seq_out", 64'(cmd_out_addr), 64'(m_out[xcnt]));
          chk("seq_last", 64'(cmd_last), 64'(m_last[xcnt]));
          l_op[xcnt]   <= cmd_op;
          l_in[xcnt]   <= cmd_in_addr;
          l_w[xcnt]    <= cmd_w_addr;
          l_out[xcnt]  <= cmd_out_addr;
          l_last[xcnt] <= cmd_last;
        end else begin
          total++;
          bad++;
          $display("FAIL extra_cmd: got transfer %0d expected at most %0d", xcnt + 1, NTOT);
        end
        xcnt <= xcnt + 1;
      end
      stall_q <= cmd_valid && !cmd_ready;
      h_op    <= cmd_op;
      h_in    <= cmd_in_addr;
      h_w     <= cmd_w_addr;
      h_out   <= cmd_out_addr;
      h_last  <= cmd_last;
    end else begin
      stall_q <= 1'b0;
    end
  end

  // mode 0 plain, 1 random backpressure, 2 drain hold, 3 start pulsed during RUN
  task automatic do_pass(input int mode, output int cyc);
    int   drain_n;
    logic busy_ok;
    drain_n = 0;
    busy_ok = 1'b1;
    xcnt    = 0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 1;
    chk("first_valid", 64'(cmd_valid), 64'd1);
    chk("first_op", 64'(cmd_op), 64'd0);
    chk("first_out", 64'(cmd_out_addr), 64'd0);
    chk("first_busy", 64'(busy), 64'd1);
    if (mode == 2) dp_idle = 1'b0;
    while (!done && cyc < 2000) begin
      if (mode == 1) cmd_ready = 1'($urandom_range(0, 1));
      if (mode == 3) start = (xcnt >= 70 && xcnt < 75);
      tick();
      cyc++;
      if (!done && !busy) busy_ok = 1'b0;
      if (mode == 2 && busy && !cmd_valid) begin
        drain_n++;
        if (drain_n == 11) dp_idle = 1'b1;
      end
    end
    cmd_ready = 1'b1;
    start     = 1'b0;
    dp_idle   = 1'b1;
    chk("done_seen", 64'(done), 64'd1);
    chk("busy_during_pass", 64'(busy_ok), 64'd1);
    chk("busy_at_done", 64'(busy), 64'd0);
    chk("valid_at_done", 64'(cmd_valid), 64'd0);
    chk("cmd_total", 64'(xcnt), 64'(NTOT));
    tick();
    chk("done_one_cycle", 64'(done), 64'd0);
  endtask

  initial begin
    int idx;
    int cyc;
    rst       = 1'b1;
    start     = 1'b0;
    dp_idle   = 1'b1;
    cmd_ready = 1'b1;

    idx = 0;
    for (int c = 0; c < 64; c++) begin
      m_op[idx] = 2'b00; m_in[idx] = '0; m_w[idx] = '0;
      m_out[idx] = AW'(c); m_last[idx] = (c == 63);
      idx++;
    end
    for (int id = 0; id < 2; id++)
      for (int ih = 0; ih < 2; ih++)
        for (int iw = 0; iw < 2; iw++)
          for (int kd = 0; kd < 2; kd++)
            for (int kh = 0; kh < 2; kh++)
              for (int kw = 0; kw < 2; kw++) begin
                m_op[idx]   = 2'b01;
                m_in[idx]   = AW'(id * 4 + ih * 2 + iw);
                m_w[idx]    = AW'(kd * 4 + kh * 2 + kw);
                m_out[idx]  = AW'((id * 2 + kd) * 16 + (ih * 2 + kh) * 4 + (iw * 2 + kw));
                m_last[idx] = (idx == NTOT - 1);
                idx++;
              end

    tbl[0] = '{0,   2'b00, 16'd0, 16'd0, 16'd0,  1'b0};
    tbl[1] = '{1,   2'b00, 16'd0, 16'd0, 16'd1,  1'b0};
    tbl[2] = '{63,  2'b00, 16'd0, 16'd0, 16'd63, 1'b1};
    tbl[3] = '{64,  2'b01, 16'd0, 16'd0, 16'd0,  1'b0};
    tbl[4] = '{71,  2'b01, 16'd0, 16'd7, 16'd21, 1'b0};
    tbl[5] = '{72,  2'b01, 16'd1, 16'd0, 16'd2,  1'b0};
    tbl[6] = '{73,  2'b01, 16'd1, 16'd1, 16'd3,  1'b0};
    tbl[7] = '{80,  2'b01, 16'd2, 16'd0, 16'd8,  1'b0};
    tbl[8] = '{127, 2'b01, 16'd7, 16'd7, 16'd63, 1'b1};

    repeat (3) tick();
    chk("rst_valid", 64'(cmd_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_last", 64'(cmd_last), 64'd0);
    chk("rst_op", 64'(cmd_op), 64'd0);
    chk("rst_addrs", 64'(cmd_in_addr | cmd_w_addr | cmd_out_addr), 64'd0);
    rst = 1'b0;
    tick();

    do_pass(0, cyc);
    chk("basic_latency", 64'(cyc), 64'd130);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("tbl%0d_op", tbl[i].idx), 64'(l_op[tbl[i].idx]), 64'(tbl[i].op));
      chk($sformatf("tbl%0d_in", tbl[i].idx), 64'(l_in[tbl[i].idx]), 64'(tbl[i].in_a));
      chk($sformatf("tbl%0d_w", tbl[i].idx), 64'(l_w[tbl[i].idx]), 64'(tbl[i].w_a));
      chk($sformatf("tbl%0d_out", tbl[i].idx), 64'(l_out[tbl[i].idx]), 64'(tbl[i].out_a));
      chk($sformatf("tbl%0d_last", tbl[i].idx), 64'(l_last[tbl[i].idx]), 64'(tbl[i].last));
    end
    repeat (2) tick();

    do_pass(3, cyc);
    chk("ignored_start_latency", 64'(cyc), 64'd130);
    repeat (2) tick();
    chk("idle_after_ignored_start", 64'(busy), 64'd0);

    do_pass(1, cyc);
    chk("backpressure_slower", 64'(cyc >= 130), 64'd1);
    repeat (2) tick();

    do_pass(2, cyc);
    chk("drain_hold_latency", 64'(cyc), 64'd140);
    repeat (2) tick();

    xcnt  = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 1;
    while (xcnt < 84 && cyc < 500) begin
      tick();
      cyc++;
    end
    chk("pre_reset_count", 64'(xcnt), 64'd84);
    chk("pre_reset_in_run", 64'(cmd_op), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrun_rst_valid", 64'(cmd_valid), 64'd0);
    chk("midrun_rst_busy", 64'(busy), 64'd0);
    chk("midrun_rst_op", 64'(cmd_op), 64'd0);
    repeat (5) tick();
    chk("no_cmd_after_rst", 64'(cmd_valid | busy), 64'd0);
    chk("no_xfer_after_rst", 64'(xcnt), 64'd84);
    do_pass(0, cyc);
    chk("restart_latency", 64'(cyc), 64'd130);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_transposed_3d_sched.md
CONV_TRANSPOSED_3D_SCHED -- requirements
Module: conv_transposed_3d_sched

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- N, 4: input cube side.
- K, 3: kernel cube side.
- S, 2: stride; padding 0, output_padding 0.
- CI, 2: input channels.
- CO, 2: output channels.
- AW, 16: address width.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: the single clock.
- rst, in, 1: reset, synchronous and active-high.
- start, in, 1: begin one layer pass.
- dp_idle, in, 1: datapath has no command in flight.
- busy, out, 1: pass in progress.
- done, out, 1: one-cycle pulse at end of pass.
- cmd_valid, out, 1: command present.
- cmd_ready, in, 1: datapath accepts the command.
- cmd_op, out, 2: 2'b00 CLEAR, 2'b01 MAC.
- cmd_in_addr, out, AW: input voxel address.
- cmd_w_addr, out, AW: weight address.
- cmd_out_addr, out, AW: output voxel address.
- cmd_last, out, 1: final command of the current phase.

Function
REQ-003 Output side SHALL be O=(N-1)*S+K, computed at elaboration time.
REQ-004 The FSM SHALL have states IDLE, CLEAR, RUN, DRAIN and DONE.
REQ-005 IDLE->CLEAR SHALL occur on start=1; start SHALL be ignored in every other state.
REQ-006 CLEAR SHALL issue CO*O^3 CLEAR commands, one per output voxel.
- Loop order co, od, oh, ow, with ow innermost.
- cmd_out_addr=((co*O+od)*O+oh)*O+ow.
- cmd_in_addr=0 and cmd_w_addr=0.
REQ-007 RUN SHALL issue N^3*CI*CO*K^3 MAC commands.
- Loop order id, ih, iw, ci, co, kd, kh, kw, with kw innermost.
- cmd_in_addr=((ci*N+id)*N+ih)*N+iw.
- cmd_w_addr=(((ci*CO+co)*K+kd)*K+kh)*K+kw.
- cmd_out_addr=((co*O+(id*S+kd))*O+(ih*S+kh))*O+(iw*S+kw).
REQ-008 A command SHALL transfer only on a cycle where cmd_valid=1 and cmd_ready=1; at most one transfer per cycle.
REQ-009 While cmd_valid=1 and cmd_ready=0, cmd_op, all addresses and cmd_last SHALL hold stable and cmd_valid SHALL stay 1.
REQ-010 On each transfer the innermost counter SHALL increment; each counter wraps to 0 at its bound and carries to the next outer counter.
REQ-011 cmd_last SHALL be 1 exactly on the final command of CLEAR and on the final command of RUN.
REQ-012 When a transfer has cmd_last=1:
- In CLEAR, the FSM SHALL go to RUN on the next cycle with all counters 0.
- In RUN, the FSM SHALL go to DRAIN.
REQ-013 cmd_valid SHALL be 1 in CLEAR and RUN with no bubble at the CLEAR->RUN boundary, and 0 in IDLE, DRAIN and DONE.
REQ-014 DRAIN SHALL go to DONE on the first cycle dp_idle=1.
REQ-015 DONE SHALL last one cycle with done=1 and then return to IDLE.
REQ-016 busy SHALL be 1 in CLEAR, RUN and DRAIN, and 0 in IDLE and DONE.
REQ-017 Latency: with start=1 in IDLE at cycle t, the first CLEAR command SHALL be valid at cycle t+1.
REQ-018 Address arithmetic SHALL be unsigned and truncated to AW bits.
- Overflow is a parameterisation error; simulation SHALL assert it at elaboration.
REQ-019 All outputs SHALL be registered.

Reset
REQ-020 On rst=1 at a clock edge, the following SHALL hold from the next cycle:
- State IDLE and all counters 0.
- cmd_valid=0, busy=0, done=0, cmd_last=0, cmd_op=2'b00 and all addresses 0.
REQ-021 rst=1 SHALL take priority over start and over a pending or in-flight handshake, including mid-CLEAR and mid-RUN.
- No further command SHALL be issued until a new start.

Verification
REQ-022 The bench SHALL cover these directed scenarios (N=2, K=2, S=2, CI=1, CO=1, O=4, cmd_ready=1, dp_idle=1):
- Basic pass: start pulse -> 64 CLEARs (addresses 0..63) then 64 MACs, then done one cycle after DRAIN; 130 cycles from start to done.
- MAC address check: MAC number 9 (id=0, ih=0, iw=1, kd=0, kh=0, kw=1) -> in_addr=1, w_addr=1, out_addr=3.
- Backpressure: cmd_ready toggles 1,0,0,1 randomly -> no command lost or duplicated; fields stable while stalled; totals still 64+64.
- Drain hold: dp_idle=0 for 10 cycles after the last MAC -> done delayed exactly 10 cycles; busy=1 throughout.
- Reset mid-RUN: rst pulse after 20 MACs -> cmd_valid=0 and busy=0 the next cycle; a new start restarts from CLEAR address 0.
- Ignored start: start asserted during RUN -> no effect on counters or command count.
